// File: rtl/gnrmc_uart_tx.sv
// gnrmc_uart_tx: serialises "$GNRMC,hhmmss.00,A*CS\r\n" as 8N1 UART.
// Define GNRMC_TX_CKSUM_EN to include the "*CS" checksum field.
module gnrmc_uart_tx #(
    parameter logic [23:0] BAUD_CNT_MAX = 24'd5207
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] hours,
    input  logic [15:0] minutes,
    input  logic [15:0] seconds,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START_BIT,
        DATA,
        STOP_BIT
    } state_t;

`ifdef GNRMC_TX_CKSUM_EN
    localparam logic [4:0] LAST_IDX = 5'd22;
`else
    localparam logic [4:0] LAST_IDX = 5'd19;
`endif

    state_t      state_q, state_d;
    logic [23:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [4:0]  idx_q, idx_d;
    logic [15:0] hh_q, hh_d;
    logic [15:0] mm_q, mm_d;
    logic [15:0] ss_q, ss_d;
    logic        tx_q, tx_d;
    logic        done_q, done_d;
    logic [7:0]  byte_d;
    logic        tick;

`ifdef GNRMC_TX_CKSUM_EN
    logic [7:0]  ck_q, ck_d;

    function automatic logic [7:0] hex(input logic [3:0] n);
        return (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
    endfunction
`endif

    assign tick = (baud_q == BAUD_CNT_MAX);
    assign tx   = tx_q;
    assign busy = (state_q != IDLE);
    assign done = done_q;

    // Next-state logic: baud/bit/byte sequencing and field latching
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        hh_d    = hh_q;
        mm_d    = mm_q;
        ss_d    = ss_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                hh_d    = hours;
                mm_d    = minutes;
                ss_d    = seconds;
                idx_d   = 5'd0;
                bit_d   = 3'd0;
                baud_d  = 24'd0;
                state_d = START_BIT;
            end
            START_BIT: begin
                if (tick) begin
                    baud_d  = 24'd0;
                    bit_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 24'd1;
                end
            end
            DATA: begin
                if (tick) begin
                    baud_d = 24'd0;
                    bit_d  = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP_BIT;
                end else begin
                    baud_d = baud_q + 24'd1;
                end
            end
            STOP_BIT: begin
                if (tick) begin
                    baud_d = 24'd0;
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = START_BIT;
                    end
                end else begin
                    baud_d = baud_q + 24'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Character for the byte index being (or about to be) sent
    always_comb begin
        byte_d = 8'h0A;
        case (idx_d)
            5'd0:  byte_d = 8'h24;
            5'd1:  byte_d = 8'h47;
            5'd2:  byte_d = 8'h4E;
            5'd3:  byte_d = 8'h52;
            5'd4:  byte_d = 8'h4D;
            5'd5:  byte_d = 8'h43;
            5'd6:  byte_d = 8'h2C;
            5'd7:  byte_d = hh_q[15:8];
            5'd8:  byte_d = hh_q[7:0];
            5'd9:  byte_d = mm_q[15:8];
            5'd10: byte_d = mm_q[7:0];
            5'd11: byte_d = ss_q[15:8];
            5'd12: byte_d = ss_q[7:0];
            5'd13: byte_d = 8'h2E;
            5'd14: byte_d = 8'h30;
            5'd15: byte_d = 8'h30;
            5'd16: byte_d = 8'h2C;
            5'd17: byte_d = 8'h41;
`ifdef GNRMC_TX_CKSUM_EN
            5'd18: byte_d = 8'h2A;
            5'd19: byte_d = hex(ck_q[7:4]);
            5'd20: byte_d = hex(ck_q[3:0]);
            5'd21: byte_d = 8'h0D;
`else
            5'd18: byte_d = 8'h0D;
`endif
            default: byte_d = 8'h0A;
        endcase
    end

    // Line level follows the state being entered, so tx is registered
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START_BIT: tx_d = 1'b0;
            DATA:      tx_d = byte_d[bit_d];
            default:   tx_d = 1'b1;
        endcase
    end

`ifdef GNRMC_TX_CKSUM_EN
    // XOR each body byte in as it is loaded for transmission
    always_comb begin
        ck_d = ck_q;
        if (state_q == LOAD) begin
            ck_d = 8'h00;
        end else if (state_q == STOP_BIT && state_d == START_BIT &&
                     idx_d >= 5'd1 && idx_d <= 5'd17) begin
            ck_d = ck_q ^ byte_d;
        end
    end

    // Checksum register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ck_q <= 8'h00;
        else        ck_q <= ck_d;
    end
`endif

    // State, counters, latched fields and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= 24'd0;
            bit_q   <= 3'd0;
            idx_q   <= 5'd0;
            hh_q    <= 16'h0000;
            mm_q    <= 16'h0000;
            ss_q    <= 16'h0000;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            hh_q    <= hh_d;
            mm_q    <= mm_d;
            ss_q    <= ss_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_gnrmc_uart_tx.sv
// tb_gnrmc_uart_tx: random and directed sentences decoded off tx
// and compared with a byte-level model of the NMEA sentence.
module tb_gnrmc_uart_tx;

    localparam int BPC = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] hours = 16'h0;
    logic [15:0] minutes = 16'h0;
    logic [15:0] seconds = 16'h0;
    logic        tx;
    logic        busy;
    logic        done;

    int errs = 0;
    int checks = 0;

    byte unsigned exp_q[$];
    bit           wave[0:1023];
    logic [7:0]   dec[0:31];

    gnrmc_uart_tx #(.BAUD_CNT_MAX(24'd3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .hours   (hours),
        .minutes (minutes),
        .seconds (seconds),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] hexch(input logic [3:0] n);
        if (n < 4'd10) return 8'd48 + 8'(n);
        return 8'd65 + 8'(n) - 8'd10;
    endfunction

    // Reference sentence built straight from the character layout
    task automatic build(input logic [15:0] h, input logic [15:0] m,
                         input logic [15:0] s);
        string hdr = "$GNRMC,";
        string mid = ".00,A";
        logic [7:0] ck = 8'h00;
        exp_q.delete();
        for (int i = 0; i < hdr.len(); i++) exp_q.push_back(hdr[i]);
        exp_q.push_back(h[15:8]);
        exp_q.push_back(h[7:0]);
        exp_q.push_back(m[15:8]);
        exp_q.push_back(m[7:0]);
        exp_q.push_back(s[15:8]);
        exp_q.push_back(s[7:0]);
        for (int i = 0; i < mid.len(); i++) exp_q.push_back(mid[i]);
        for (int i = 1; i < exp_q.size(); i++) ck = ck ^ exp_q[i];
`ifdef GNRMC_TX_CKSUM_EN
        exp_q.push_back(8'h2A);
        exp_q.push_back(hexch(ck[7:4]));
        exp_q.push_back(hexch(ck[3:0]));
`endif
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    // Called #1 after a posedge; returns #1 after the edge that sampled start
    task automatic fire(input logic [15:0] h, input logic [15:0] m,
                        input logic [15:0] s);
        hours = h;
        minutes = m;
        seconds = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Record one full sentence, then check done timing, bytes and bit widths
    task automatic capture(input string tag, input int glitch);
        int n = exp_q.size();
        int len = n * 10 * BPC;
        int dn = 0;
        int bad = 0;
        logic [7:0] b;
        bit eb;
        for (int c = 0; c < len; c++) begin
            @(posedge clk);
            #1;
            wave[c] = tx;
            if (done) dn++;
            if (c == glitch) begin
                start = 1'b1;
                hours = 16'h3030;
                minutes = 16'h3030;
                seconds = 16'h3030;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_early_done"}, dn, 0);
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < 8; j++)
                b[j] = wave[(k * 10 + 1 + j) * BPC + BPC / 2];
            dec[k] = b;
            chk($sformatf("%s_byte%0d", tag, k), b, exp_q[k]);
        end
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < 10; i++) begin
                eb = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : exp_q[k][i - 1];
                for (int q = 0; q < BPC; q++)
                    if (wave[(k * 10 + i) * BPC + q] != eb) bad++;
            end
        end
        chk({tag, "_wave"}, bad, 0);
    endtask

    task automatic rand_field(output logic [15:0] f);
        for (int i = 0; i < 2; i++) begin
            if ($urandom_range(0, 3) == 0)
                f[i*8 +: 8] = 8'($urandom_range(0, 255));
            else
                f[i*8 +: 8] = 8'(8'd48 + 8'($urandom_range(0, 9)));
        end
    endtask

    logic [15:0] nh, nm, ns;
    logic [15:0] rh, rm, rs;

    initial begin
        int bad;
        nh = "12";
        nm = "34";
        ns = "56";

        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 1000; c++) begin
            @(posedge clk);
            #1;
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        chk("idle_quiet", bad, 0);

        build(nh, nm, ns);
        fire(nh, nm, ns);
        chk("nom_busy", busy, 1);
        chk("nom_load_tx", tx, 1);
        capture("nom", -1);
`ifdef GNRMC_TX_CKSUM_EN
        chk("nom_ck_hi", dec[19], 8'h33);
        chk("nom_ck_lo", dec[20], 8'h44);
`endif
        @(posedge clk);
        #1;
        chk("nom_done_1cyc", done, 0);

        build(nh, nm, ns);
        fire(nh, nm, ns);
        capture("reissue", 300);
        @(posedge clk);
        #1;
        chk("reissue_done_1cyc", done, 0);
        chk("reissue_no_queue", busy, 0);

        build(nh, nm, ns);
        fire(nh, nm, ns);
        capture("b2b1", -1);
        fire(nh, nm, ns);
        chk("b2b_busy", busy, 1);
        chk("b2b_load_tx", tx, 1);
        capture("b2b2", -1);
`ifdef GNRMC_TX_CKSUM_EN
        chk("b2b_ck_hi", dec[19], 8'h33);
        chk("b2b_ck_lo", dec[20], 8'h44);
`endif

        @(posedge clk);
        #1;
        fire(nh, nm, ns);
        repeat (401) @(posedge clk);
        #1;
        chk("pre_rst_tx", tx, 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_tx", tx, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        @(posedge clk);
        #1;
        chk("midrst_hold_done", done, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        build(nh, nm, ns);
        fire(nh, nm, ns);
        capture("after_rst", -1);

        for (int r = 0; r < 4; r++) begin
            rand_field(rh);
            rand_field(rm);
            rand_field(rs);
            @(posedge clk);
            #1;
            build(rh, rm, rs);
            fire(rh, rm, rs);
            capture($sformatf("rand%0d", r), -1);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/gnrmc_uart_tx.md
# gnrmc_uart_tx

Generates a fixed-format NMEA time sentence, "$GNRMC,hhmmss.00,A*CS" followed by CR LF, from ASCII-digit time fields. Serialises it as 8N1 UART on a single `tx` line. It is the transmit counterpart of the GPS receive path (UART receiver plus GNRMC decoder), so the board can emit or loop back time sentences for self-test.

## Interface
- `BAUD_CNT_MAX`, default 24'd5207: cycles per bit minus one (9600 Bd at 50 MHz).
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to send one sentence.
- `hours`  in  16  two ASCII digits: [15:8] tens, [7:0] units.
- `minutes`  in  16  two ASCII digits, same layout.
- `seconds`  in  16  two ASCII digits, same layout.
- `tx`  out  1  UART serial output, idle high.
- `busy`  out  1  high while a sentence is in flight.
- `done`  out  1  one-cycle pulse when the last stop bit completes.

## Operation
- Reset values: `tx`=1, `busy`=0, `done`=0. All counters, the byte index and the checksum register are 0. The FSM is in IDLE.
- FSM states and transitions:
  - IDLE -> LOAD on `start` while `busy`=0.
  - LOAD is one cycle. It latches `hours`, `minutes` and `seconds` and clears the checksum.
  - LOAD -> START_BIT -> DATA (8 bits, LSB first) -> STOP_BIT.
  - From STOP_BIT, go to START_BIT for the next byte, or to IDLE after the final byte.
- Byte sequence, by index:
  - 0: '$'
  - 1–6: "GNRMC,"
  - 7–12: hours tens, hours units, minutes tens, minutes units, seconds tens, seconds units
  - 13–16: ".00,"
  - 17: 'A'
  - then '*', checksum high nibble, checksum low nibble, 0x0D, 0x0A
  - Total: 23 bytes.
- Checksum: 8-bit XOR of bytes 1–17. It is accumulated as each byte is loaded for transmission. Each nibble is converted to uppercase ASCII hex (0–9 -> 0x30–0x39, A–F -> 0x41–0x46).
- Input digits are not range-checked; they are transmitted verbatim.
- `start` while `busy`=1 is ignored. It is not queued.
- Input changes after LOAD have no effect on the current sentence.
- `rst_n` low mid-sentence:
  - `tx` returns high asynchronously and `busy` drops to 0.
  - No `done` pulse is produced.
  - A truncated frame on the line is acceptable.

## Timing
- `start` sampled high at edge N:
  - `busy`=1 from N+1.
  - LOAD occupies N+1; `tx` drives the first start bit (0) from N+2.
- Each bit lasts exactly `BAUD_CNT_MAX`+1 cycles; each byte lasts 10 bits.
- Sentence length L = 23×10×(`BAUD_CNT_MAX`+1) cycles, with no idle gap between bytes.
- Cycle N+2+L (the cycle after the last stop bit's final cycle):
  - `done`=1 for that one cycle.
  - `busy`=0 in the same cycle, and the FSM is in IDLE.
  - A `start` in that cycle is accepted.
- The bit counter wraps from 7 to 0 on byte boundaries. The baud counter wraps at `BAUD_CNT_MAX`.

## Configuration
- `GNRMC_TX_CKSUM_EN` defined:
  - '*' and the two checksum characters are sent (23 bytes).
  - The checksum datapath is present.
- Undefined:
  - The sentence ends "...,A" then CR LF (20 bytes).
  - The checksum register and hex conversion are removed.
  - L = 20×10×(`BAUD_CNT_MAX`+1).

## Test plan
- Reset behaviour: hold `rst_n`=0 -> `tx`=1, `busy`=0, `done`=0. Release with no `start` -> `tx` stays 1 for 1000 cycles.
- Nominal sentence, `BAUD_CNT_MAX`=3, macro defined: `hours`="12", `minutes`="34", `seconds`="56".
  - A UART monitor decodes "$GNRMC,123456.00,A*3D\r\n".
  - `done` pulses at N+2+920.
  - Every bit is 4 cycles wide.
- Macro undefined, same stimulus: decodes "$GNRMC,123456.00,A\r\n"; `done` at N+2+800.
- `start` reissued while `busy`, and inputs changed to "00" mid-frame: the output is identical to the nominal sentence, and exactly one `done` pulse occurs.
- Reset mid-frame at byte 10: `tx`=1 immediately and `busy`=0. A new `start` then sends a complete, correct sentence.
- Back-to-back: `start` asserted in the `done` cycle -> the second start bit begins 2 cycles later. Both sentences decode correctly, with checksum "3D".
